// File: rtl/cmd_assembler_pkg.sv
// Shared constants and state encoding for the SUMP command assembler.
// Imported by the RTL and available to anything that decodes its framing.
package cmd_assembler_pkg;

  localparam int LONG_CMD_BIT   = 7;
  localparam int LONG_CMD_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

endpackage

// File: rtl/cmd_assembler.sv
// Assembles SUMP short/long commands from a byte stream into cmd_code/cmd_data/cmd_exe.
// Partial long commands are dropped after TIMEOUT idle cycles, with a cmd_err pulse.
module cmd_assembler
  import cmd_assembler_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_data,
  output logic        cmd_exe,
  output logic        cmd_err,
  output logic        busy
);

  localparam logic [1:0]    LAST_IDX = 2'(LONG_CMD_BYTES - 1);
  localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [1:0]    idx, idx_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [7:0]    pend_code, pend_code_nx;
  logic [31:0]   pend_data, pend_data_nx;
  logic [31:0]   merged;
  logic [7:0]    code_nx;
  logic [31:0]   data_nx;
  logic          exe_nx, err_nx;

  // The state register doubles as the externally visible busy flag.
  assign busy = (state == DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      tcnt      <= '0;
      pend_code <= '0;
      pend_data <= '0;
      cmd_code  <= '0;
      cmd_data  <= '0;
      cmd_exe   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      tcnt      <= tcnt_nx;
      pend_code <= pend_code_nx;
      pend_data <= pend_data_nx;
      cmd_code  <= code_nx;
      cmd_data  <= data_nx;
      cmd_exe   <= exe_nx;
      cmd_err   <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    tcnt_nx      = tcnt;
    pend_code_nx = pend_code;
    pend_data_nx = pend_data;
    code_nx      = cmd_code;
    data_nx      = cmd_data;
    exe_nx       = 1'b0;
    err_nx       = 1'b0;
    // Pending word with the incoming byte dropped into its little-endian slot.
    merged                       = pend_data;
    merged[{idx, 3'b000} +: 8]   = rx_data;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[LONG_CMD_BIT]) begin
            pend_code_nx = rx_data;
            pend_data_nx = '0;
            idx_nx       = '0;
            tcnt_nx      = '0;
            state_nx     = DATA;
          end else begin
            code_nx = rx_data;
            data_nx = '0;
            exe_nx  = 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          // A byte arriving on the last allowed idle cycle still wins over expiry.
          tcnt_nx      = '0;
          pend_data_nx = merged;
          if (idx == LAST_IDX) begin
            code_nx  = pend_code;
            data_nx  = merged;
            exe_nx   = 1'b1;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + 2'd1;
          end
        end else if (tcnt == TCNT_MAX) begin
          state_nx     = IDLE;
          err_nx       = 1'b1;
          tcnt_nx      = '0;
          idx_nx       = '0;
          pend_code_nx = '0;
          pend_data_nx = '0;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
